// File: rtl/profile_configurator_pkg.sv
// Shared definitions for the SPI profile configurator: command byte layout,
// FSM state encoding and byte-count helpers.
package profile_configurator_pkg;

  localparam int unsigned CMD_BITS    = 8;
  localparam int unsigned CMD_RW      = 7;
  localparam int unsigned CMD_FIELD   = 6;
  localparam int unsigned CMD_IDX_MSB = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } cfg_state_t;

  // Bytes carrying a tuning word of m bits (m is a multiple of b).
  function automatic int unsigned word_bytes(input int unsigned m, input int unsigned b);
    return m / b;
  endfunction

  // Bytes carrying a phase offset of n bits, rounded up to whole bytes.
  function automatic int unsigned poff_bytes(input int unsigned n, input int unsigned b);
    return (n + b - 1) / b;
  endfunction

  // A command index addresses a real profile only below p.
  function automatic logic idx_valid(input logic [CMD_IDX_MSB:0] idx, input int unsigned p);
    return 32'(idx) < p;
  endfunction

endpackage

// File: rtl/spi_sync_shifter.sv
// SPI front end running on the system clock: pin synchronisers, sclk/ss edge
// detection, receive bit counter and byte strobe, and (with
// PROFILE_READBACK_EN) the mode-0 miso shifter.
module spi_sync_shifter #(
  parameter int unsigned B = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         sclk,
  input  logic         mosi,
  input  logic         ss,
  output logic         ss_active,
  output logic         ss_fall,
  output logic         rx_valid,
  output logic [B-1:0] rx_byte
`ifdef PROFILE_READBACK_EN
  ,
  input  logic [B-1:0] tx_byte,
  output logic         tx_load,
  output logic         miso
`endif
);

  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(B - 1);

  logic [1:0]    sclk_ff, mosi_ff, ss_ff;
  logic          sclk_d, ss_d;
  logic          sclk_s, mosi_s;
  logic          sclk_rise;
  logic [BW-1:0] bit_cnt;
  logic [B-2:0]  rx_sh;

  // Two-flop synchronisers plus one delay stage for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_ff <= '0;
      mosi_ff <= '0;
      ss_ff   <= '1;
      sclk_d  <= 1'b0;
      ss_d    <= 1'b1;
    end else begin
      sclk_ff <= {sclk_ff[0], sclk};
      mosi_ff <= {mosi_ff[0], mosi};
      ss_ff   <= {ss_ff[0], ss};
      sclk_d  <= sclk_ff[1];
      ss_d    <= ss_ff[1];
    end
  end

  assign sclk_s    = sclk_ff[1];
  assign mosi_s    = mosi_ff[1];
  assign ss_active = ~ss_ff[1];
  assign ss_fall   = ~ss_ff[1] & ss_d;
  assign sclk_rise = sclk_s & ~sclk_d & ss_active;

  // Receive shifter and bit counter; both restart whenever ss is inactive.
  always_ff @(posedge clk) begin
    if (reset || !ss_active) begin
      bit_cnt <= '0;
      rx_sh   <= '0;
    end else if (sclk_rise) begin
      rx_sh   <= rx_byte[B-2:0];
      bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end
  end

  // Byte is presented in the same cycle its last bit is sampled.
  assign rx_byte  = {rx_sh, mosi_s};
  assign rx_valid = sclk_rise && (bit_cnt == LAST_BIT);

`ifdef PROFILE_READBACK_EN
  logic         sclk_fall;
  logic [B-1:0] tx_sh;

  assign sclk_fall = ~sclk_s & sclk_d & ss_active;
  // The first falling edge of each byte (counter back at zero) loads a new byte.
  assign tx_load   = sclk_fall && (bit_cnt == '0);

  // Mode-0 transmit: miso changes only on sclk falling edges, MSB first.
  always_ff @(posedge clk) begin
    if (reset || !ss_active) begin
      tx_sh <= '0;
      miso  <= 1'b0;
    end else if (tx_load) begin
      miso  <= tx_byte[B-1];
      tx_sh <= {tx_byte[B-2:0], 1'b0};
    end else if (sclk_fall) begin
      miso  <= tx_sh[B-1];
      tx_sh <= {tx_sh[B-2:0], 1'b0};
    end
  end
`endif

endmodule

// File: rtl/profile_configurator.sv
// Multi-profile DDS configuration store programmed over SPI. The profile
// selected by prof_sel drives word/poff with a one-cycle load strobe.
// Optional read-back path is built only when PROFILE_READBACK_EN is defined.
module profile_configurator
  import profile_configurator_pkg::*;
#(
  parameter int unsigned M = 48,
  parameter int unsigned N = 14,
  parameter int unsigned B = 8,
  parameter int unsigned P = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sclk,
  input  logic                 mosi,
  input  logic                 ss,
  output logic                 miso,
  input  logic [$clog2(P)-1:0] prof_sel,
  output logic [M-1:0]         word,
  output logic [N-1:0]         poff,
  output logic                 load,
  output logic                 busy
);

  localparam int unsigned IW       = $clog2(P);
  localparam int unsigned WB       = word_bytes(M, B);
  localparam int unsigned PB       = poff_bytes(N, B);
  localparam int unsigned CW       = (WB > 1) ? $clog2(WB) : 1;
  localparam logic [CW-1:0] LAST_W = CW'(WB - 1);
  localparam logic [CW-1:0] LAST_P = CW'(PB - 1);
  // Bytes shift in from the top, so a short phase-offset field ends up here.
  localparam int unsigned POFF_LSB = M - PB * B;

  cfg_state_t            state_q, state_d;
  logic [CMD_BITS-1:0]   cmd_q;
  logic [CW-1:0]         byte_cnt;
  logic [M-1:0]          shadow;
  logic [M-1:0]          wr_data;
  logic [M-1:0]          word_mem [P];
  logic [N-1:0]          poff_mem [P];
  logic [IW-1:0]         sel_q;
  logic                  init_q;

  logic                  ss_active, ss_fall, rx_valid;
  logic [B-1:0]          rx_byte;

  logic                  cmd_wr, cmd_field, cmd_ok, last_byte, commit, hit, upd;
  logic [IW-1:0]         tgt;
  logic [M-1:0]          word_nx;
  logic [N-1:0]          poff_nx;

`ifdef PROFILE_READBACK_EN
  logic [B-1:0]          tx_byte;
  logic                  tx_load;
  logic [M-1:0]          snap;
  logic [CMD_IDX_MSB:0]  rd_idx;
`endif

  spi_sync_shifter #(
    .B (B)
  ) u_spi (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .mosi      (mosi),
    .ss        (ss),
    .ss_active (ss_active),
    .ss_fall   (ss_fall),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte)
`ifdef PROFILE_READBACK_EN
    ,
    .tx_byte   (tx_byte),
    .tx_load   (tx_load),
    .miso      (miso)
`endif
  );

  assign cmd_wr    = cmd_q[CMD_RW];
  assign cmd_field = cmd_q[CMD_FIELD];
  assign cmd_ok    = idx_valid(cmd_q[CMD_IDX_MSB:0], P);
  assign tgt       = cmd_q[IW-1:0];
  assign last_byte = (byte_cnt == (cmd_field ? LAST_P : LAST_W));
  // Shadow with the final byte merged in, so the commit is a single-cycle write.
  assign wr_data   = {rx_byte, shadow[M-1:B]};
  assign commit    = (state_q == DATA) && rx_valid && last_byte && cmd_wr && cmd_ok;
  assign busy      = (state_q != IDLE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; ss going inactive overrides every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ss_fall) state_d = CMD;
      CMD: begin
        if (rx_valid) begin
`ifdef PROFILE_READBACK_EN
          state_d = DATA;
`else
          state_d = rx_byte[CMD_RW] ? DATA : DONE;
`endif
        end
      end
      DATA: if (rx_valid && last_byte) state_d = DONE;
      DONE: state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (!ss_active) state_d = IDLE;
  end

  // Command latch, byte counter and write shadow.
  always_ff @(posedge clk) begin
    if (reset || !ss_active) begin
      cmd_q    <= '0;
      byte_cnt <= '0;
      shadow   <= '0;
    end else if (rx_valid) begin
      case (state_q)
        CMD: begin
          cmd_q    <= rx_byte[CMD_BITS-1:0];
          byte_cnt <= '0;
          shadow   <= '0;
        end
        DATA: begin
          shadow   <= wr_data;
          byte_cnt <= byte_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Profile storage; only a completed, in-range write touches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < P; i++) begin
        word_mem[i] <= '0;
        poff_mem[i] <= '0;
      end
    end else if (commit) begin
      if (cmd_field) poff_mem[tgt] <= wr_data[POFF_LSB +: N];
      else           word_mem[tgt] <= wr_data;
    end
  end

  // Newest values for the selected profile, bypassing a same-cycle commit.
  always_comb begin
    hit     = commit && (tgt == prof_sel);
    upd     = (prof_sel != sel_q) || hit;
    word_nx = '0;
    poff_nx = '0;
    if (32'(prof_sel) < P) begin
      word_nx = word_mem[prof_sel];
      poff_nx = poff_mem[prof_sel];
    end
    if (hit && !cmd_field) word_nx = wr_data;
    if (hit && cmd_field)  poff_nx = wr_data[POFF_LSB +: N];
  end

  // Registered output path; the first cycle out of reset only tracks prof_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      word   <= '0;
      poff   <= '0;
      load   <= 1'b0;
      sel_q  <= '0;
      init_q <= 1'b1;
    end else begin
      sel_q  <= prof_sel;
      init_q <= 1'b0;
      load   <= upd && !init_q;
      if (upd || init_q) begin
        word <= word_nx;
        poff <= poff_nx;
      end
    end
  end

`ifdef PROFILE_READBACK_EN
  assign rd_idx  = rx_byte[CMD_IDX_MSB:0];
  assign tx_byte = (state_q == DATA && !cmd_wr) ? snap[B-1:0] : '0;

  // Read snapshot taken at the end of CMD, consumed one byte per tx_load.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap <= '0;
    end else if (state_q == CMD && rx_valid) begin
      if (!idx_valid(rd_idx, P))      snap <= '0;
      else if (rx_byte[CMD_FIELD])    snap <= M'(poff_mem[rd_idx[IW-1:0]]);
      else                            snap <= word_mem[rd_idx[IW-1:0]];
    end else if (tx_load) begin
      snap <= snap >> B;
    end
  end
`else
  assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_profile_configurator.sv
// Directed self-checking bench for profile_configurator (SPI mode 0 host model).
module tb_profile_configurator;

  localparam int unsigned M    = 48;
  localparam int unsigned N    = 14;
  localparam int unsigned B    = 8;
  localparam int unsigned P    = 4;
  localparam int          HALF = 5;

  logic         clk = 1'b0;
  logic         reset, sclk, mosi, ss, miso, load, busy;
  logic [1:0]   prof_sel;
  logic [M-1:0] word;
  logic [N-1:0] poff;

  int checks   = 0;
  int errors   = 0;
  int load_cnt = 0;
  int load_base;
  logic [63:0] rd;
  logic [7:0]  dummy;

  profile_configurator #(.M(M), .N(N), .B(B), .P(P)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .ss(ss), .miso(miso),
    .prof_sel(prof_sel), .word(word), .poff(poff), .load(load), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load === 1'b1) load_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      clks(HALF);
      rx[i] = miso;
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic spi_begin();
    ss = 1'b0;
    clks(HALF);
  endtask

  task automatic spi_end();
    clks(HALF);
    ss   = 1'b1;
    mosi = 1'b0;
    clks(2 * HALF);
  endtask

  task automatic spi_write(input logic [7:0] cmd, input logic [63:0] data, input int nbytes);
    logic [7:0] r;
    spi_begin();
    spi_xfer(cmd, r);
    for (int k = 0; k < nbytes; k++) spi_xfer(data[8*k +: 8], r);
    spi_end();
  endtask

  task automatic spi_read(input logic [7:0] cmd, input int nbytes, output logic [63:0] data);
    logic [7:0] r;
    data = '0;
    spi_begin();
    spi_xfer(cmd, r);
    for (int k = 0; k < nbytes; k++) begin
      spi_xfer(8'h00, r);
      data[8*k +: 8] = r;
    end
    spi_end();
  endtask

  initial begin
    reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0; prof_sel = 2'd2;
    clks(2);
    check("reset_word", 64'(word), 64'd0);
    check("reset_poff", 64'(poff), 64'd0);
    check("reset_load", 64'(load), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_miso", 64'(miso), 64'd0);
    reset = 1'b0;
    clks(4);
    check("no_load_after_reset", 64'(load_cnt), 64'd0);

    // Tuning word write to the selected profile.
    load_base = load_cnt;
    spi_write(8'h82, 64'h0000_0123_4567_89AB, 6);
    check("wr_word_p2", 64'(word), 64'h0000_0123_4567_89AB);
    check("wr_word_p2_load", 64'(load_cnt - load_base), 64'd1);

    // Phase offset write to a non-selected profile, high bits ignored.
    prof_sel = 2'd0;
    clks(3);
    load_base = load_cnt;
    spi_write(8'hC1, 64'h0000_0000_0000_FFFF, 2);
    check("wr_poff_p1_noload", 64'(load_cnt - load_base), 64'd0);
    check("wr_poff_p1_poff_unsel", 64'(poff), 64'd0);
    prof_sel = 2'd1;
    clks(3);
    check("sel_p1_poff", 64'(poff), 64'h3FFF);
    check("sel_p1_word", 64'(word), 64'd0);
    check("sel_p1_load", 64'(load_cnt - load_base), 64'd1);

    // Profile 0 = 1, then an aborted write must leave it untouched.
    prof_sel = 2'd0;
    clks(3);
    spi_write(8'h80, 64'h1, 6);
    check("wr_p0_word", 64'(word), 64'h1);
    load_base = load_cnt;
    spi_write(8'h80, 64'hFF_FFFF, 3);
    check("abort_word", 64'(word), 64'h1);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_noload", 64'(load_cnt - load_base), 64'd0);
    prof_sel = 2'd1;
    clks(3);
    prof_sel = 2'd0;
    clks(3);
    check("abort_p0_reload", 64'(word), 64'h1);

    // Profile 3 write and read-back.
    load_base = load_cnt;
    spi_write(8'h83, 64'h0000_AAAA_5555_0F0F, 6);
    check("wr_p3_noload", 64'(load_cnt - load_base), 64'd0);
    spi_read(8'h03, 6, rd);
    for (int k = 0; k < 6; k++) begin
      logic [7:0] exp_b;
      logic [63:0] ref_v;
      ref_v = 64'h0000_AAAA_5555_0F0F;
`ifdef PROFILE_READBACK_EN
      exp_b = ref_v[8*k +: 8];
`else
      exp_b = 8'h00;
`endif
      check($sformatf("rd_p3_byte%0d", k), 64'(rd[8*k +: 8]), 64'(exp_b));
    end
    spi_read(8'h41, 2, rd);
`ifdef PROFILE_READBACK_EN
    check("rd_p1_poff", rd, 64'h3FFF);
`else
    check("rd_p1_poff", rd, 64'h0);
`endif
    spi_read(8'h05, 1, rd);
    check("rd_invalid_idx", rd, 64'h0);

    // Invalid index write with trailing bytes.
    spi_begin();
    spi_xfer(8'h85, dummy);
    for (int k = 0; k < 8; k++) spi_xfer((k < 6) ? 8'hEE : 8'h77, dummy);
    check("invalid_done_busy", 64'(busy), 64'd1);
    spi_end();
    check("invalid_idle_busy", 64'(busy), 64'd0);
    check("inv_p0_word", 64'(word), 64'h1);
    check("inv_p0_poff", 64'(poff), 64'h0);
    prof_sel = 2'd1;
    clks(3);
    check("inv_p1_word", 64'(word), 64'h0);
    check("inv_p1_poff", 64'(poff), 64'h3FFF);
    prof_sel = 2'd3;
    clks(3);
    check("inv_p3_word", 64'(word), 64'h0000_AAAA_5555_0F0F);
    prof_sel = 2'd2;
    clks(3);
    check("inv_p2_word", 64'(word), 64'h0000_0123_4567_89AB);

    // Reset in the middle of a data phase.
    spi_begin();
    spi_xfer(8'h82, dummy);
    spi_xfer(8'h11, dummy);
    spi_xfer(8'h22, dummy);
    check("mid_data_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    ss    = 1'b1;
    mosi  = 1'b0;
    clks(1);
    check("midrst_word", 64'(word), 64'd0);
    check("midrst_poff", 64'(poff), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_load", 64'(load), 64'd0);
    clks(1);
    reset = 1'b0;
    clks(4);
    load_base = load_cnt;
    spi_write(8'h82, 64'h0000_6655_4433_2211, 6);
    check("post_rst_word", 64'(word), 64'h0000_6655_4433_2211);
    check("post_rst_load", 64'(load_cnt - load_base), 64'd1);
    prof_sel = 2'd3;
    clks(3);
    check("post_rst_p3_cleared", 64'(word), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
